// File: rtl/currency_collector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// currency_collector: sums accepted notes against a due amount, then settles
// (insert + change) or refunds on cancel/timeout.                    rev 1.0
// ----------------------------------------------------------------------------
module currency_collector #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 10,
   parameter int MAX_NOTES      = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] due_amount,
   input  logic       cancel,
   input  logic       note_valid,
   input  logic [2:0] note_code,
   output logic       note_ready,
   output logic       note_reject,
   output logic [7:0] total_amount,
   output logic       busy,
   output logic       currency_inserted,
   output logic [7:0] currency_amount,
   output logic [7:0] change_amount,
   output logic       refund_valid,
   output logic [7:0] refund_amount
);

   localparam int NW = $clog2(MAX_NOTES + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_REPORT  = 2'd2,
      S_REFUND  = 2'd3
   } state_t;

   state_t           state_q;
   logic [7:0]       due_q;
   logic [7:0]       total_q;
   logic [NW-1:0]    count_q;
   logic [CNT_W-1:0] timer_q;
   logic             note_reject_q;
   logic             currency_inserted_q;
   logic [7:0]       currency_amount_q;
   logic [7:0]       change_amount_q;
   logic             refund_valid_q;
   logic [7:0]       refund_amount_q;

   logic [7:0] note_value;
   logic [8:0] sum_d;
   logic       accept_d;

   always_comb begin
      note_value = 8'd0;
      case (note_code)
         3'd0:    note_value = 8'd1;
         3'd1:    note_value = 8'd2;
         3'd2:    note_value = 8'd5;
         3'd3:    note_value = 8'd10;
         3'd4:    note_value = 8'd20;
         3'd5:    note_value = 8'd50;
         3'd6:    note_value = 8'd100;
         default: note_value = 8'd200;
      endcase
   end

   // 9-bit sum so a note that would wrap past 255 is refused rather than absorbed
   assign sum_d    = {1'b0, total_q} + {1'b0, note_value};
   assign accept_d = note_valid && !cancel && (count_q < NW'(MAX_NOTES)) && !sum_d[8];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q             <= S_IDLE;
         due_q               <= 8'd0;
         total_q             <= 8'd0;
         count_q             <= '0;
         timer_q             <= '0;
         note_reject_q       <= 1'b0;
         currency_inserted_q <= 1'b0;
         currency_amount_q   <= 8'd0;
         change_amount_q     <= 8'd0;
         refund_valid_q      <= 1'b0;
         refund_amount_q     <= 8'd0;
      end else begin
         note_reject_q       <= 1'b0;
         currency_inserted_q <= 1'b0;
         currency_amount_q   <= 8'd0;
         change_amount_q     <= 8'd0;
         refund_valid_q      <= 1'b0;
         refund_amount_q     <= 8'd0;
         case (state_q)
            S_IDLE: begin
               if (start && (due_amount != 8'd0)) begin
                  due_q   <= due_amount;
                  total_q <= 8'd0;
                  count_q <= '0;
                  timer_q <= '0;
                  state_q <= S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (cancel) begin
                  note_reject_q <= note_valid;
                  if (total_q != 8'd0) state_q <= S_REFUND;
                  else                 state_q <= S_IDLE;
               end else if (accept_d) begin
                  total_q <= sum_d[7:0];
                  count_q <= count_q + NW'(1);
                  timer_q <= '0;
                  if (sum_d[7:0] >= due_q) state_q <= S_REPORT;
               end else begin
                  note_reject_q <= note_valid;
                  if (timer_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                     if (total_q != 8'd0) state_q <= S_REFUND;
                     else                 state_q <= S_IDLE;
                  end else begin
                     timer_q <= timer_q + CNT_W'(1);
                  end
               end
            end
            S_REPORT: begin
               currency_inserted_q <= 1'b1;
               currency_amount_q   <= due_q;
               change_amount_q     <= total_q - due_q;
               state_q             <= S_IDLE;
            end
            S_REFUND: begin
               refund_valid_q  <= 1'b1;
               refund_amount_q <= total_q;
               total_q         <= 8'd0;
               state_q         <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign note_ready        = (state_q == S_COLLECT);
   assign busy              = (state_q != S_IDLE);
   assign note_reject       = note_reject_q;
   assign total_amount      = total_q;
   assign currency_inserted = currency_inserted_q;
   assign currency_amount   = currency_amount_q;
   assign change_amount     = change_amount_q;
   assign refund_valid      = refund_valid_q;
   assign refund_amount     = refund_amount_q;

endmodule
`default_nettype wire

// File: tb/tb_currency_collector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_currency_collector: directed and randomized transactions vs. a
// transaction-level payment model.                                   rev 1.0
// ----------------------------------------------------------------------------
module tb_currency_collector;

   localparam int T    = 64;
   localparam int MAXN = 16;

   logic       clk        = 1'b0;
   logic       reset      = 1'b0;
   logic       start      = 1'b0;
   logic [7:0] due_amount = 8'd0;
   logic       cancel     = 1'b0;
   logic       note_valid = 1'b0;
   logic [2:0] note_code  = 3'd0;
   logic       note_ready, note_reject, busy, currency_inserted, refund_valid;
   logic [7:0] total_amount, currency_amount, change_amount, refund_amount;

   currency_collector #(
      .TIMEOUT_CYCLES(T),
      .CNT_W(10),
      .MAX_NOTES(MAXN)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .due_amount(due_amount),
      .cancel(cancel),
      .note_valid(note_valid),
      .note_code(note_code),
      .note_ready(note_ready),
      .note_reject(note_reject),
      .total_amount(total_amount),
      .busy(busy),
      .currency_inserted(currency_inserted),
      .currency_amount(currency_amount),
      .change_amount(change_amount),
      .refund_valid(refund_valid),
      .refund_amount(refund_amount)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ins_cnt = 0, ref_cnt = 0, exp_ins = 0, exp_ref = 0;

   // Transaction-level model of the payment in progress
   int m_due, m_total, m_count, m_quiet;
   bit m_active = 1'b0;

   always @(negedge clk) begin
      if (currency_inserted) ins_cnt++;
      if (refund_valid)      ref_cnt++;
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int value_of(input int code);
      int table_v[8] = '{1, 2, 5, 10, 20, 50, 100, 200};
      return table_v[code];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tick();
      m_quiet++;
   endtask

   task automatic check_counts();
      check("ins_count", ins_cnt, exp_ins);
      check("refund_count", ref_cnt, exp_ref);
   endtask

   task automatic begin_txn(input int due);
      check("idle_busy", busy, 0);
      start = 1'b1;
      due_amount = 8'(due);
      tick();
      start = 1'b0;
      if (due == 0) begin
         check("zero_due_busy", busy, 0);
         m_active = 1'b0;
         return;
      end
      m_due = due; m_total = 0; m_count = 0; m_quiet = 0; m_active = 1'b1;
      check("start_busy", busy, 1);
      check("start_total", total_amount, 0);
      check("start_ready", note_ready, 1);
      // start while busy must not reload the due amount
      start = 1'b1;
      due_amount = 8'd1;
      idle();
      start = 1'b0;
      due_amount = 8'd0;
      check("restart_busy", busy, 1);
   endtask

   task automatic offer(input int code);
      bit acc;
      int v;
      v = value_of(code);
      check("offer_ready", note_ready, 1);
      note_valid = 1'b1;
      note_code = 3'(code);
      tick();
      note_valid = 1'b0;
      acc = (m_count < MAXN) && (m_total + v <= 255);
      if (acc) begin
         m_total += v;
         m_count++;
         m_quiet = 0;
      end else begin
         m_quiet++;
      end
      check("total", total_amount, m_total);
      check("reject", note_reject, acc ? 0 : 1);
      if (acc && m_total >= m_due) begin
         check("report_ready", note_ready, 0);
         check("report_busy", busy, 1);
         check("report_ins_early", currency_inserted, 0);
         note_valid = 1'b1;
         note_code = 3'd7;
         tick();
         note_valid = 1'b0;
         exp_ins++;
         check("ins", currency_inserted, 1);
         check("ins_amount", currency_amount, m_due);
         check("change", change_amount, m_total - m_due);
         check("ins_busy", busy, 0);
         check("total_hold", total_amount, m_total);
         tick();
         check("ins_drop", currency_inserted, 0);
         check("amount_drop", currency_amount, 0);
         check("change_drop", change_amount, 0);
         check_counts();
         m_active = 1'b0;
      end
   endtask

   task automatic refund_tail();
      if (m_total != 0) begin
         check("refund_state_busy", busy, 1);
         tick();
         exp_ref++;
         check("refund_valid", refund_valid, 1);
         check("refund_amount", refund_amount, m_total);
         check("refund_busy", busy, 0);
         check("refund_total_clr", total_amount, 0);
         tick();
         check("refund_drop", refund_valid, 0);
         check("refund_amt_drop", refund_amount, 0);
      end else begin
         check("empty_exit_busy", busy, 0);
         check("empty_no_refund", refund_valid, 0);
      end
      check_counts();
      m_active = 1'b0;
   endtask

   task automatic cancel_txn(input bit with_note);
      cancel = 1'b1;
      note_valid = with_note;
      note_code = 3'($urandom_range(0, 7));
      tick();
      cancel = 1'b0;
      note_valid = 1'b0;
      check("cancel_reject", note_reject, with_note ? 1 : 0);
      check("cancel_total", total_amount, m_total);
      refund_tail();
   endtask

   task automatic timeout_txn();
      int remain;
      remain = T - m_quiet;
      repeat (remain - 1) tick();
      check("pre_timeout_busy", busy, 1);
      check("pre_timeout_ready", note_ready, 1);
      tick();
      refund_tail();
   endtask

   initial begin
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_ready", note_ready, 0);
      check("rst_total", total_amount, 0);
      check("rst_ins", currency_inserted, 0);
      check("rst_refund", refund_valid, 0);
      reset = 1'b1;
      tick();

      begin_txn(50);  offer(4); offer(4); offer(3);
      begin_txn(35);  offer(4); offer(4);
      begin_txn(100); offer(5); cancel_txn(1'b0);
      begin_txn(250); offer(7); offer(5);
      begin_txn(255); offer(7); offer(5); offer(3); timeout_txn();

      begin_txn(255);
      repeat (MAXN) offer(0);
      offer(0); offer(7);
      cancel_txn(1'b1);

      begin_txn(40); cancel_txn(1'b1);
      begin_txn(0);
      begin_txn(60); timeout_txn();

      begin_txn(50); offer(4); offer(3);
      check("pre_reset_total", total_amount, 30);
      reset = 1'b0;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_total", total_amount, 0);
      check("async_rst_ready", note_ready, 0);
      check("async_rst_reject", note_reject, 0);
      tick();
      reset = 1'b1;
      m_active = 1'b0;
      tick();
      check_counts();
      begin_txn(10); offer(3);

      for (int t = 0; t < 40; t++) begin
         begin_txn($urandom_range(1, 255));
         for (int k = 0; k < 12 && m_active; k++) begin
            repeat ($urandom_range(0, 2)) idle();
            offer($urandom_range(0, 7));
         end
         if (m_active) begin
            if ($urandom_range(0, 3) == 0) timeout_txn();
            else cancel_txn(1'($urandom_range(0, 1)));
         end
      end
      check_counts();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
